// File: rtl/bus_arbiter_wdt_if.sv
// Shared-bus request/grant bundle between the bus masters and the arbiter.
// The arbiter side uses the slave modport; the requesters use the master modport.
interface bus_arbiter_wdt_if #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2
);
    logic [NUM_MASTERS-1:0] m_req_;
    logic [NUM_MASTERS-1:0] m_grnt_;
    logic [OWNER_W-1:0]     owner;
    logic                   bus_as_;
    logic                   bus_rdy_;

    modport master (
        output m_req_, bus_as_, bus_rdy_,
        input  m_grnt_, owner
    );

    modport slave (
        input  m_req_, bus_as_, bus_rdy_,
        output m_grnt_, owner
    );
endinterface

// File: rtl/bus_arbiter_wdt.sv
// Round-robin system-bus arbiter with a watchdog that revokes the grant from
// a master left waiting on a slave that never asserts bus_rdy_.
//
// state  | meaning
// IDLE   | no grant outstanding, waiting for an eligible request
// GRANT  | one master owns the bus, watchdog counting wait cycles
// REVOKE | one dead cycle with all grants high after a watchdog timeout
module bus_arbiter_wdt #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8
) (
    input  logic                clk,
    input  logic                reset_,
    bus_arbiter_wdt_if.slave    bus,
    output logic                busy,
    output logic                timeout_err,
    output logic [OWNER_W-1:0]  err_master
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        REVOKE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grnt_, grnt_nxt_;
    logic [NUM_MASTERS-1:0] mask, mask_nxt, mask_set;
    logic [OWNER_W-1:0]     owner_r, owner_nxt;
    logic [OWNER_W-1:0]     last, last_nxt;
    logic [OWNER_W-1:0]     err_master_r, err_master_nxt;
    logic [TO_W-1:0]        wait_cnt, wait_cnt_nxt;
    logic                   timeout_err_r, timeout_err_nxt;
    logic                   busy_r, busy_nxt;

    logic [NUM_MASTERS-1:0] eligible;
    logic                   pick_vld;
    logic [OWNER_W-1:0]     pick;
    logic                   released;
    logic                   wait_cyc;
    logic                   timeout;

    assign eligible = ~bus.m_req_ & ~mask;
    assign released = bus.m_req_[owner_r];
    assign wait_cyc = (state == GRANT) && !bus.bus_as_ && bus.bus_rdy_;
    assign timeout  = wait_cyc && (wait_cnt == TO_W'(TIMEOUT - 1));

    // A releasing owner has req_ high, so it is never in the eligible set here.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!pick_vld && eligible[idx[OWNER_W-1:0]]) begin
                pick_vld = 1'b1;
                pick     = OWNER_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state         <= IDLE;
            grnt_         <= '1;
            owner_r       <= '0;
            last          <= OWNER_W'(NUM_MASTERS - 1);
            mask          <= '0;
            wait_cnt      <= '0;
            timeout_err_r <= 1'b0;
            err_master_r  <= '0;
            busy_r        <= 1'b0;
        end else begin
            state         <= state_nxt;
            grnt_         <= grnt_nxt_;
            owner_r       <= owner_nxt;
            last          <= last_nxt;
            mask          <= mask_nxt;
            wait_cnt      <= wait_cnt_nxt;
            timeout_err_r <= timeout_err_nxt;
            err_master_r  <= err_master_nxt;
            busy_r        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = GRANT;
            GRANT: begin
                if (timeout)       state_nxt = REVOKE;
                else if (released) state_nxt = pick_vld ? GRANT : IDLE;
            end
            REVOKE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grnt_nxt_       = grnt_;
        owner_nxt       = owner_r;
        last_nxt        = last;
        mask_set        = '0;
        wait_cnt_nxt    = '0;
        timeout_err_nxt = 1'b0;
        err_master_nxt  = err_master_r;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grnt_nxt_       = '1;
                    grnt_nxt_[pick] = 1'b0;
                    owner_nxt       = pick;
                    last_nxt        = pick;
                end
            end
            GRANT: begin
                if (timeout) begin
                    grnt_nxt_         = '1;
                    timeout_err_nxt   = 1'b1;
                    err_master_nxt    = owner_r;
                    mask_set[owner_r] = 1'b1;
                end else if (released) begin
                    grnt_nxt_ = '1;
                    if (pick_vld) begin
                        grnt_nxt_[pick] = 1'b0;
                        owner_nxt       = pick;
                        last_nxt        = pick;
                    end
                end else if (wait_cyc) begin
                    wait_cnt_nxt = wait_cnt + TO_W'(1);
                end
            end
            default: grnt_nxt_ = '1;
        endcase
        // Mask set and clear may coincide; a high req_ always wins.
        mask_nxt = (mask | mask_set) & ~bus.m_req_;
        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.m_grnt_ = grnt_;
    assign bus.owner   = owner_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;
    assign err_master  = err_master_r;

endmodule

// File: tb/tb_bus_arbiter_wdt.sv
// Directed bench for bus_arbiter_wdt (4 masters, TIMEOUT=4): a vector table for
// reset/round-robin/single-requester plus hand sequences for watchdog and reset.
module tb_bus_arbiter_wdt;

    typedef struct {
        logic       reset_;
        logic [3:0] m_req_;
        logic       bus_as_;
        logic       bus_rdy_;
        logic [3:0] exp_grnt_;
        logic [1:0] exp_owner;
        logic       exp_busy;
        logic       exp_terr;
        logic [1:0] exp_errm;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_;
    logic       busy;
    logic       timeout_err;
    logic [1:0] err_master;

    int n_cmp = 0;
    int n_err = 0;

    bus_arbiter_wdt_if #(.NUM_MASTERS(4), .OWNER_W(2)) bus ();

    bus_arbiter_wdt #(
        .NUM_MASTERS(4),
        .OWNER_W    (2),
        .TIMEOUT    (4),
        .TO_W       (8)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .bus        (bus.slave),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_master (err_master)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic as_,
                                input logic rdy_, input logic [3:0] g, input logic [1:0] o,
                                input logic b, input logic t, input logic [1:0] e);
        vec_t v;
        v.reset_ = r;    v.m_req_ = q;    v.bus_as_ = as_; v.bus_rdy_ = rdy_;
        v.exp_grnt_ = g; v.exp_owner = o; v.exp_busy = b;  v.exp_terr = t;
        v.exp_errm = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        reset_       = v.reset_;
        bus.m_req_   = v.m_req_;
        bus.bus_as_  = v.bus_as_;
        bus.bus_rdy_ = v.bus_rdy_;
        @(posedge clk);
        #1;
        check({tag, ".grnt_"},  8'(bus.m_grnt_), 8'(v.exp_grnt_));
        check({tag, ".owner"},  8'(bus.owner),   8'(v.exp_owner));
        check({tag, ".busy"},   8'(busy),        8'(v.exp_busy));
        check({tag, ".terr"},   8'(timeout_err), 8'(v.exp_terr));
        check({tag, ".errm"},   8'(err_master),  8'(v.exp_errm));
        check({tag, ".onehot"}, 8'($countones(~bus.m_grnt_) <= 1), 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];

        reset_       = 1'b0;
        bus.m_req_   = 4'b1111;
        bus.bus_as_  = 1'b1;
        bus.bus_rdy_ = 1'b1;

        // reset with everyone requesting, then master 0 first
        tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b1111, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b1111, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 1, 1, 4'b1110, 0, 1, 0, 0));
        // round robin 0,1,2,3,0 with direct handoff, 3 grant cycles each
        tbl.push_back(mk(1, 4'b0000, 1, 1, 4'b1110, 0, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 1, 1, 4'b1110, 0, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 1, 1, 4'b1101, 1, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 1, 1, 4'b1101, 1, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 1, 1, 4'b1101, 1, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 1, 1, 4'b1011, 2, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 1, 1, 4'b1011, 2, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 1, 1, 4'b1011, 2, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0110, 1, 1, 4'b0111, 3, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0110, 1, 1, 4'b0111, 3, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0110, 1, 1, 4'b0111, 3, 1, 0, 0));
        tbl.push_back(mk(1, 4'b1110, 1, 1, 4'b1110, 0, 1, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0));
        // single requester 2 holds req_ low for 5 edges
        tbl.push_back(mk(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0));
        tbl.push_back(mk(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0));
        tbl.push_back(mk(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0));
        tbl.push_back(mk(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0));
        tbl.push_back(mk(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 2, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 2, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // watchdog: master 1 waits forever, master 3 queues behind it
        step(mk(1, 4'b1101, 1, 1, 4'b1101, 1, 1, 0, 0), "wdt_grant");
        step(mk(1, 4'b0101, 0, 1, 4'b1101, 1, 1, 0, 0), "wdt_wait1");
        step(mk(1, 4'b0101, 0, 1, 4'b1101, 1, 1, 0, 0), "wdt_wait2");
        step(mk(1, 4'b0101, 0, 1, 4'b1101, 1, 1, 0, 0), "wdt_wait3");
        step(mk(1, 4'b0101, 0, 1, 4'b1111, 1, 1, 1, 1), "wdt_revoke");
        step(mk(1, 4'b0101, 1, 1, 4'b1111, 1, 0, 0, 1), "wdt_dead");
        step(mk(1, 4'b0101, 1, 1, 4'b0111, 3, 1, 0, 1), "wdt_m3");
        step(mk(1, 4'b1101, 1, 1, 4'b1111, 3, 0, 0, 1), "wdt_masked1");
        step(mk(1, 4'b1101, 1, 1, 4'b1111, 3, 0, 0, 1), "wdt_masked2");
        step(mk(1, 4'b1111, 1, 1, 4'b1111, 3, 0, 0, 1), "wdt_unmask");
        step(mk(1, 4'b1101, 1, 1, 4'b1101, 1, 1, 0, 1), "wdt_regrant");

        // watchdog clear: one ready cycle after 3 waits restarts the count
        step(mk(1, 4'b1101, 0, 1, 4'b1101, 1, 1, 0, 1), "clr_wait1");
        step(mk(1, 4'b1101, 0, 1, 4'b1101, 1, 1, 0, 1), "clr_wait2");
        step(mk(1, 4'b1101, 0, 1, 4'b1101, 1, 1, 0, 1), "clr_wait3");
        step(mk(1, 4'b1101, 0, 0, 4'b1101, 1, 1, 0, 1), "clr_ready");
        step(mk(1, 4'b1101, 0, 1, 4'b1101, 1, 1, 0, 1), "clr_rewait1");
        step(mk(1, 4'b1101, 0, 1, 4'b1101, 1, 1, 0, 1), "clr_rewait2");
        step(mk(1, 4'b1101, 0, 1, 4'b1101, 1, 1, 0, 1), "clr_rewait3");
        step(mk(1, 4'b1101, 0, 1, 4'b1111, 1, 1, 1, 1), "clr_revoke");
        step(mk(1, 4'b1111, 1, 1, 4'b1111, 1, 0, 0, 1), "clr_dead");

        // reset mid-grant: master 2 owns, reset drops everything, master 0 wins
        step(mk(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 1), "rst_grant");
        step(mk(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 1), "rst_hold");
        step(mk(0, 4'b0000, 1, 1, 4'b1111, 0, 0, 0, 0), "rst_apply");
        step(mk(1, 4'b0000, 1, 1, 4'b1110, 0, 1, 0, 0), "rst_first");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
